axi_response_frame_builder: RTL and testbench

Downstream stage of the AXI4-Lite master. When a transaction completes, it latches the result: status, command echo, address echo and read bytes. It then serialises a UART response frame byte by byte over a valid/ready stream into the UART TX path, appending a CRC-8. It is the only source of response frames on the TX side of the UART-AXI4 bridge.

---
 rtl/axi_response_frame_builder.sv | 200 ++++++++++++++++++++
 tb/tb_axi_response_frame_builder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_response_frame_builder.sv
// axi_response_frame_builder
// Captures the result of a finished AXI4-Lite transaction and serialises it
// as a UART response frame: SOF, STATUS, CMD, [ADDR x4, DATA x L], CRC-8.
// The CRC covers STATUS through the last DATA byte; SOF is excluded.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for build_response; busy=0, tx_valid=0
// S_SOF    | presenting start-of-frame byte
// S_STATUS | presenting latched status code
// S_CMD    | presenting latched command echo
// S_ADDR   | presenting latched address, LSB first (4 bytes)
// S_DATA   | presenting latched read bytes 0..L-1
// S_CRC    | presenting final CRC-8 over STATUS..last DATA byte
module axi_response_frame_builder #(
  parameter logic [7:0] SOF_RESP       = 8'h2D,
  parameter logic [7:0] CRC_POLY       = 8'h07,
  parameter int         MAX_DATA_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        build_response,
  input  logic [7:0]  status_code,
  input  logic [7:0]  cmd_echo,
  input  logic [31:0] addr_echo,
  input  logic [7:0]  response_data [0:MAX_DATA_BYTES-1],
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int IDX_W = $clog2(MAX_DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_STATUS,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CRC
  } state_t;

  state_t          state;
  logic [7:0]      status_r;
  logic [7:0]      cmd_r;
  logic [31:0]     addr_r;
  logic [7:0]      data_r [0:MAX_DATA_BYTES-1];
  logic [6:0]      len_r;
  logic [6:0]      data_idx;
  logic [1:0]      addr_idx;
  logic [7:0]      crc;
  logic [7:0]      crc_next;
  logic [6:0]      len_base;
  logic [6:0]      len_calc;
  logic [IDX_W-1:0] data_sel;
  logic            hs;
  logic            accept;

  // One MSB-first CRC-8 step over a full byte, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] din);
    logic [7:0] c;
    c = crc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = (c << 1) ^ CRC_POLY;
      else      c = c << 1;
    end
    return c;
  endfunction

  assign hs       = tx_valid & tx_ready;
  assign accept   = (state == S_IDLE) & build_response;
  assign data_sel = data_idx[IDX_W-1:0] + IDX_W'(1);

  // Payload length and running CRC including the byte currently on the bus.
  always_comb begin
    len_base = {3'b000, cmd_echo[3:0]} + 7'd1;
    len_calc = 7'd0;
    if (cmd_echo[7] && (status_code == 8'h00) && (cmd_echo[5:4] != 2'b11))
      len_calc = len_base << cmd_echo[5:4];
    crc_next = crc8_byte(crc, tx_data);
  end

  // Read-data buffer snapshot, taken only when a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < MAX_DATA_BYTES; i++)
        data_r[i] <= response_data[i];
    end
  end

  // Frame sequencer: advances one byte per handshake, outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      crc        <= 8'h00;
      data_idx   <= 7'd0;
      addr_idx   <= 2'd0;
      len_r      <= 7'd0;
      status_r   <= 8'h00;
      cmd_r      <= 8'h00;
      addr_r     <= 32'h0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (build_response) begin
            status_r <= status_code;
            cmd_r    <= cmd_echo;
            addr_r   <= addr_echo;
            len_r    <= len_calc;
            crc      <= 8'h00;
            data_idx <= 7'd0;
            addr_idx <= 2'd0;
            tx_data  <= SOF_RESP;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_SOF;
          end
        end
        S_SOF: begin
          if (hs) begin
            tx_data <= status_r;
            state   <= S_STATUS;
          end
        end
        S_STATUS: begin
          if (hs) begin
            crc     <= crc_next;
            tx_data <= cmd_r;
            state   <= S_CMD;
          end
        end
        S_CMD: begin
          if (hs) begin
            crc <= crc_next;
            if (len_r != 7'd0) begin
              // Address goes out LSB first; shift the copy down as we go.
              tx_data  <= addr_r[7:0];
              addr_r   <= {8'h00, addr_r[31:8]};
              addr_idx <= 2'd0;
              state    <= S_ADDR;
            end else begin
              tx_data <= crc_next;
              state   <= S_CRC;
            end
          end
        end
        S_ADDR: begin
          if (hs) begin
            crc <= crc_next;
            if (addr_idx == 2'd3) begin
              tx_data  <= data_r[0];
              data_idx <= 7'd0;
              state    <= S_DATA;
            end else begin
              tx_data  <= addr_r[7:0];
              addr_r   <= {8'h00, addr_r[31:8]};
              addr_idx <= addr_idx + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            crc <= crc_next;
            if (data_idx == len_r - 7'd1) begin
              tx_data <= crc_next;
              state   <= S_CRC;
            end else begin
              tx_data  <= data_r[data_sel];
              data_idx <= data_idx + 7'd1;
            end
          end
        end
        S_CRC: begin
          if (hs) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_response_frame_builder.sv
// Bench for axi_response_frame_builder: directed and random frames compared
// against a frame model built from the protocol rules.
module tb_axi_response_frame_builder;

  localparam logic [7:0] SOF = 8'h2D;

  logic        clk = 1'b0;
  logic        rst;
  logic        build_response;
  logic [7:0]  status_code;
  logic [7:0]  cmd_echo;
  logic [31:0] addr_echo;
  logic [7:0]  resp_data [0:63];
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  logic [7:0]  ref_data [0:63];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  axi_response_frame_builder dut (
    .clk            (clk),
    .rst            (rst),
    .build_response (build_response),
    .status_code    (status_code),
    .cmd_echo       (cmd_echo),
    .addr_echo      (addr_echo),
    .response_data  (resp_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Expected frame from the rules: header, optional address+data, CRC.
  task automatic model(input logic [7:0] s, input logic [7:0] c, input logic [31:0] a);
    int len;
    logic [7:0] cr;
    exp_q.delete();
    len = 0;
    if (c[7] == 1'b1 && s == 8'h00 && c[5:4] != 2'b11)
      len = (int'(c[3:0]) + 1) * (1 << c[5:4]);
    exp_q.push_back(SOF);
    exp_q.push_back(s);
    exp_q.push_back(c);
    if (len > 0) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((a >> (8 * k)) & 32'hFF));
      for (int k = 0; k < len; k++) exp_q.push_back(ref_data[k]);
    end
    cr = 8'h00;
    for (int k = 1; k < exp_q.size(); k++) cr = crc8(cr, exp_q[k]);
    exp_q.push_back(cr);
  endtask

  task automatic randomize_ref();
    foreach (ref_data[k]) ref_data[k] = 8'($urandom);
  endtask

  task automatic scramble_inputs();
    status_code = 8'($urandom);
    cmd_echo    = 8'($urandom);
    addr_echo   = $urandom;
    foreach (resp_data[k]) resp_data[k] = 8'($urandom);
  endtask

  // Issue a request at the next negedge; check SOF the cycle after acceptance.
  task automatic send_req(input logic [7:0] s, input logic [7:0] c, input logic [31:0] a);
    @(negedge clk);
    status_code    = s;
    cmd_echo       = c;
    addr_echo      = a;
    resp_data      = ref_data;
    build_response = 1'b1;
    @(negedge clk);
    build_response = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== SOF || busy !== 1'b1) begin
      bad++;
      $display("FAIL sof_latency: valid=%b data=%h busy=%b expected valid=1 data=%h busy=1",
               tx_valid, tx_data, busy, SOF);
    end
    scramble_inputs();
  endtask

  // Collect one frame starting at the current negedge. Returns at the
  // negedge where frame_done is seen, or where reset was asserted.
  task automatic run_frame(input int stall_idx, input int stall_len, input bit inject,
                           input bit rand_rdy, input int abort_idx);
    int stalls;
    int last_hs;
    bit holding;
    bit done;
    logic [7:0] held;
    stalls  = 0;
    last_hs = -10;
    holding = 1'b0;
    done    = 1'b0;
    held    = 8'h00;
    got.delete();
    for (int c = 0; c < 3000 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (frame_done === 1'b1) begin
        total++;
        if (last_hs != c - 1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL end_of_frame: last_hs=%0d done_at=%0d valid=%b busy=%b expected done one cycle after last handshake with valid=0 busy=0",
                   last_hs, c, tx_valid, busy);
        end
        tx_ready       = 1'b1;
        build_response = 1'b0;
        done           = 1'b1;
      end else if (abort_idx >= 0 && got.size() == abort_idx) begin
        rst  = 1'b1;
        done = 1'b1;
      end else begin
        total++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL no_bubble: valid=%b busy=%b at byte %0d expected valid=1 busy=1",
                   tx_valid, busy, got.size());
        end
        if (stall_idx >= 0 && got.size() == stall_idx && stalls < stall_len) begin
          tx_ready       = 1'b0;
          build_response = inject;
          stalls++;
        end else if (rand_rdy && $urandom_range(0, 3) == 0) begin
          tx_ready       = 1'b0;
          build_response = 1'b0;
        end else begin
          tx_ready       = 1'b1;
          build_response = 1'b0;
        end
        if (tx_ready) begin
          got.push_back(tx_data);
          last_hs = c;
          holding = 1'b0;
        end else begin
          if (holding) begin
            total++;
            if (tx_data !== held) begin
              bad++;
              $display("FAIL hold_stable: data=%h expected %h", tx_data, held);
            end
          end
          held    = tx_data;
          holding = 1'b1;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: frame did not finish, got %0d bytes expected %0d",
               got.size(), exp_q.size());
      tx_ready = 1'b1;
    end
  endtask

  task automatic check_frame(input string name);
    int n;
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d bytes expected %0d", name, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      total++;
      if (got[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b expected 0 00 0 0",
               tx_valid, tx_data, busy, frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_ok();
    randomize_ref();
    exp_q = {8'h2D, 8'h00, 8'h20, 8'hE0};
    send_req(8'h00, 8'h20, 32'hDEADBEEF);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("write_ok");
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: frame_done=%b expected 0", frame_done);
    end
  endtask

  task automatic test_read_word();
    logic [7:0] cr;
    randomize_ref();
    ref_data[0] = 8'h12; ref_data[1] = 8'h34; ref_data[2] = 8'h56; ref_data[3] = 8'h78;
    exp_q = {8'h2D, 8'h00, 8'hA0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    cr = 8'h00;
    for (int k = 1; k < 11; k++) cr = crc8(cr, exp_q[k]);
    exp_q.push_back(cr);
    send_req(8'h00, 8'hA0, 32'h0000_1000);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("read_word");
  endtask

  task automatic test_read_error();
    randomize_ref();
    model(8'h03, 8'hAF, 32'h1234_5678);
    send_req(8'h03, 8'hAF, 32'h1234_5678);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("read_error");
    model(8'h00, 8'hB0, 32'h0000_0040);
    send_req(8'h00, 8'hB0, 32'h0000_0040);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("size3");
  endtask

  task automatic test_max_burst();
    randomize_ref();
    model(8'h00, 8'hAF, 32'h8000_0000);
    send_req(8'h00, 8'hAF, 32'h8000_0000);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("max_burst");
    total++;
    if (got.size() != 72 || got[70] !== ref_data[63]) begin
      bad++;
      $display("FAIL max_burst_last: size=%0d last_data=%h expected size=72 last_data=%h",
               got.size(), (got.size() > 70) ? got[70] : 8'hxx, ref_data[63]);
    end
  endtask

  task automatic test_backpressure();
    randomize_ref();
    model(8'h00, 8'hE1, 32'hCAFE_F00D);
    send_req(8'h00, 8'hE1, 32'hCAFE_F00D);
    run_frame(4, 3, 1'b1, 1'b0, -1);
    check_frame("backpressure");
    send_req(8'h00, 8'hE1, 32'hCAFE_F00D);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("backpressure_repeat");
  endtask

  task automatic test_reset_mid_data();
    randomize_ref();
    model(8'h00, 8'hAF, 32'h0BAD_CAFE);
    send_req(8'h00, 8'hAF, 32'h0BAD_CAFE);
    run_frame(-1, 0, 1'b0, 1'b0, 15);
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: valid=%b busy=%b expected 0 0", tx_valid, busy);
    end
    rst = 1'b0;
    randomize_ref();
    model(8'h00, 8'h97, 32'h0000_0100);
    send_req(8'h00, 8'h97, 32'h0000_0100);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] s2;
    logic [7:0] c2;
    logic [31:0] a2;
    randomize_ref();
    model(8'h00, 8'hA4, 32'h0000_2000);
    send_req(8'h00, 8'hA4, 32'h0000_2000);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("b2b_first");
    randomize_ref();
    s2 = 8'h00; c2 = 8'h91; a2 = 32'h1357_9BDF;
    model(s2, c2, a2);
    status_code    = s2;
    cmd_echo       = c2;
    addr_echo      = a2;
    resp_data      = ref_data;
    build_response = 1'b1;
    @(negedge clk);
    build_response = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== SOF) begin
      bad++;
      $display("FAIL b2b_sof: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, SOF);
    end
    scramble_inputs();
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    check_frame("b2b_second");
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [7:0] c;
    logic [31:0] a;
    for (int it = 0; it < 10; it++) begin
      randomize_ref();
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      c = 8'($urandom);
      a = $urandom;
      model(s, c, a);
      send_req(s, c, a);
      run_frame(-1, 0, 1'b0, 1'b1, -1);
      check_frame("random");
    end
  endtask

  initial begin
    rst            = 1'b1;
    build_response = 1'b0;
    tx_ready       = 1'b1;
    status_code    = 8'h00;
    cmd_echo       = 8'h00;
    addr_echo      = 32'h0;
    foreach (resp_data[k]) resp_data[k] = 8'h00;
    foreach (ref_data[k]) ref_data[k] = 8'h00;
    test_reset();
    test_write_ok();
    test_read_word();
    test_read_error();
    test_max_burst();
    test_backpressure();
    test_reset_mid_data();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
